// File: rtl/fpga_config_loader.sv
// fpga_config_loader: serialises config words LSB-first into the fabric shift chain, then commits with one set pulse
module fpga_config_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              shift_out,
  output logic              set_out,
  output logic              cen,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_sent
);
  localparam int IDX_W = WORD_W > 1 ? $clog2(WORD_W) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SET, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] bits_sent_q, bits_sent_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic last_bit, last_idx;
  assign last_bit  = bits_sent_q >= CNT_W'(CHAIN_LEN - 1);
  assign last_idx  = idx_q == IDX_W'(WORD_W - 1);
  assign bits_sent = bits_sent_q;
  // state and datapath registers; reset abandons any partial load without committing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bits_sent_q <= '0;
      word_q      <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      bits_sent_q <= bits_sent_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
    end
  end
  // next state: fetch a word, shift it out, refetch until the chain is full, then commit
  always_comb begin
    state_d     = state_q;
    bits_sent_d = bits_sent_q;
    word_d      = word_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d     = LOAD;
        bits_sent_d = '0;
      end
      LOAD: if (cfg_valid) begin
        word_d  = cfg_data;
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bits_sent_d = bits_sent_q == CNT_W'(CHAIN_LEN) ? bits_sent_q : bits_sent_q + 1'b1;
        idx_d       = idx_q + 1'b1;
        state_d     = last_bit ? SET : last_idx ? LOAD : SHIFT;
      end
      SET:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are pure functions of state so the chain only moves in SHIFT
  always_comb begin
    cfg_ready = state_q == LOAD;
    cen       = state_q == SHIFT;
    shift_out = state_q == SHIFT ? word_q[idx_q] : 1'b0;
    set_out   = state_q == SET;
    busy      = state_q == LOAD || state_q == SHIFT || state_q == SET;
    done      = state_q == DONE;
  end
endmodule

// File: tb/tb_fpga_config_loader.sv
// tb_fpga_config_loader: directed checks of the config loader for chain lengths 40, 64 and 1
module tb_fpga_config_loader;
  logic clk, rst;
  logic start_a, valid_a, rdy_a, so_a, set_a, cen_a, busy_a, done_a;
  logic [31:0] data_a;
  logic [5:0] bs_a;
  logic start_b, valid_b, rdy_b, so_b, set_b, cen_b, busy_b, done_b;
  logic [31:0] data_b;
  logic [6:0] bs_b;
  logic start_c, valid_c, rdy_c, so_c, set_c, cen_c, busy_c, done_c;
  logic [31:0] data_c;
  logic [0:0] bs_c;
  int n_checks = 0, n_fail = 0;
  logic [31:0] wa [2] = '{32'hA5A5A5A5, 32'h000000FF};
  int a_cen[$];
  bit a_bits[$];
  int a_sets, a_setok, a_so_bad, a_gap_ready, a_acc;
  bit a_done_seen;

  fpga_config_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cfg_data(data_a), .cfg_valid(valid_a), .cfg_ready(rdy_a),
    .shift_out(so_a), .set_out(set_a), .cen(cen_a), .busy(busy_a), .done(done_a), .bits_sent(bs_a));
  fpga_config_loader #(.WORD_W(32), .CHAIN_LEN(64)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cfg_data(data_b), .cfg_valid(valid_b), .cfg_ready(rdy_b),
    .shift_out(so_b), .set_out(set_b), .cen(cen_b), .busy(busy_b), .done(done_b), .bits_sent(bs_b));
  fpga_config_loader #(.WORD_W(32), .CHAIN_LEN(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .cfg_data(data_c), .cfg_valid(valid_c), .cfg_ready(rdy_c),
    .shift_out(so_c), .set_out(set_c), .cen(cen_c), .busy(busy_c), .done(done_c), .bits_sent(bs_c));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit exp_bit(input int i);
    logic [31:0] w;
    w = i < 32 ? 32'hA5A5A5A5 : 32'h000000FF;
    return w[i % 32];
  endfunction

  task automatic run_a(input int gap, input int stop_bits, input bit spam);
    int lc = 0;
    bit prev_cen = 0;
    a_cen.delete(); a_bits.delete();
    a_sets = 0; a_setok = 0; a_so_bad = 0; a_gap_ready = 0; a_acc = 0; a_done_seen = 0;
    start_a = 1; valid_a = 1; data_a = wa[0];
    @(negedge clk);
    start_a = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done_a) begin a_done_seen = 1; break; end
      a_cen.push_back(int'(cen_a));
      if (cen_a) a_bits.push_back(so_a); else if (so_a) a_so_bad++;
      if (set_a) begin a_sets++; if (prev_cen && a_bits.size() == 40) a_setok++; end
      prev_cen = cen_a;
      if (stop_bits != 0 && a_bits.size() == stop_bits) break;
      start_a = spam && cen_a;
      if (rdy_a && a_acc == 1) lc++;
      valid_a = !(a_acc == 1 && rdy_a && lc <= gap);
      a_gap_ready += int'(rdy_a && !valid_a && !cen_a);
      data_a = wa[a_acc > 1 ? 1 : a_acc];
      if (rdy_a && valid_a) a_acc++;
      @(negedge clk);
    end
    start_a = 0; valid_a = 0;
  endtask

  task automatic check_bits_a(input string name);
    int bad = 0;
    for (int i = 0; i < a_bits.size(); i++) if (a_bits[i] !== exp_bit(i)) bad++;
    n_checks++;
    if (a_bits.size() != 40 || bad != 0) begin
      n_fail++;
      $display("FAIL %s bits: got %0d bits with %0d wrong, required 40 bits with 0 wrong", name, a_bits.size(), bad);
    end
  endtask

  task automatic check_done_a(input string name);
    n_checks++;
    if (!a_done_seen || done_a !== 1'b1 || bs_a !== 6'd40 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: done=%b bits_sent=%0d busy=%b, required done=1 bits_sent=40 busy=0", name, done_a, bs_a, busy_a);
    end
    n_checks++;
    if (a_sets !== 1 || a_setok !== 1 || a_so_bad !== 0) begin
      n_fail++;
      $display("FAIL %s set: pulses=%0d after_last=%0d so_when_idle=%0d, required 1 1 0", name, a_sets, a_setok, a_so_bad);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    start_a = 0; valid_a = 0; data_a = 0;
    start_b = 0; valid_b = 0; data_b = 0;
    start_c = 0; valid_c = 0; data_c = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    n_checks++;
    if ({rdy_a, so_a, set_a, cen_a, busy_a, done_a} !== 6'b0 || bs_a !== 6'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b bits_sent=%0d, required 000000 bits_sent=0",
               {rdy_a, so_a, set_a, cen_a, busy_a, done_a}, bs_a);
    end
  endtask

  task automatic test_basic_load;
    int bad = 0;
    run_a(0, 0, 0);
    for (int i = 0; i < a_cen.size(); i++) if (a_cen[i] != int'((i >= 1 && i <= 32) || (i >= 34 && i <= 41))) bad++;
    n_checks++;
    if (a_cen.size() != 43 || bad != 0) begin
      n_fail++;
      $display("FAIL basic cen pattern: %0d cycles, %0d wrong, required 43 cycles, 0 wrong", a_cen.size(), bad);
    end
    n_checks++;
    if (a_acc != 2) begin
      n_fail++;
      $display("FAIL basic words: accepted %0d, required 2", a_acc);
    end
    check_bits_a("basic");
    check_done_a("basic");
  endtask

  task automatic test_valid_gap;
    int hi = 0;
    run_a(5, 0, 0);
    foreach (a_cen[i]) hi += a_cen[i];
    n_checks++;
    if (hi != 40 || a_cen.size() != 48) begin
      n_fail++;
      $display("FAIL gap cen: high=%0d cycles=%0d, required high=40 cycles=48", hi, a_cen.size());
    end
    n_checks++;
    if (a_gap_ready != 5) begin
      n_fail++;
      $display("FAIL gap stall: ready-without-shift cycles=%0d, required 5", a_gap_ready);
    end
    check_bits_a("gap");
    check_done_a("gap");
  endtask

  task automatic test_mid_reset;
    run_a(0, 20, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++;
    if ({rdy_a, so_a, set_a, cen_a, busy_a, done_a} !== 6'b0 || bs_a !== 6'd0 || a_sets != 0) begin
      n_fail++;
      $display("FAIL mid reset: got %b bits_sent=%0d sets=%0d, required 000000 bits_sent=0 sets=0",
               {rdy_a, so_a, set_a, cen_a, busy_a, done_a}, bs_a, a_sets);
    end
    run_a(0, 0, 0);
    check_bits_a("after_reset");
    check_done_a("after_reset");
  endtask

  task automatic test_start_spam;
    run_a(0, 0, 1);
    check_bits_a("spam");
    check_done_a("spam");
  endtask

  task automatic test_two_words;
    int acc = 0, rdy_bad = 0;
    logic [31:0] wb [3] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
    start_b = 1; valid_b = 1; data_b = wb[0];
    @(negedge clk);
    start_b = 0;
    for (int cyc = 0; cyc < 200 && !done_b; cyc++) begin
      data_b = wb[acc];
      if (rdy_b && valid_b) acc++;
      @(negedge clk);
    end
    data_b = wb[2];
    repeat (3) begin
      if (rdy_b !== 1'b0) rdy_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (acc != 2 || rdy_bad != 0) begin
      n_fail++;
      $display("FAIL two_words accept: accepted=%0d late_ready=%0d, required 2 0", acc, rdy_bad);
    end
    n_checks++;
    if (done_b !== 1'b1 || bs_b !== 7'd64) begin
      n_fail++;
      $display("FAIL two_words done: done=%b bits_sent=%0d, required 1 64", done_b, bs_b);
    end
    start_b = 1;
    @(negedge clk);
    start_b = 0; valid_b = 0;
    n_checks++;
    if (bs_b !== 7'd0 || rdy_b !== 1'b1 || done_b !== 1'b0 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL two_words restart: bits_sent=%0d ready=%b done=%b busy=%b, required 0 1 0 1", bs_b, rdy_b, done_b, busy_b);
    end
  endtask

  task automatic test_single_bit;
    start_c = 1; valid_c = 1; data_c = 32'h00000001;
    @(negedge clk);
    start_c = 0;
    n_checks++;
    if (rdy_c !== 1'b1 || cen_c !== 1'b0) begin
      n_fail++;
      $display("FAIL single load: ready=%b cen=%b, required 1 0", rdy_c, cen_c);
    end
    @(negedge clk);
    valid_c = 0;
    n_checks++;
    if (cen_c !== 1'b1 || so_c !== 1'b1 || rdy_c !== 1'b0 || set_c !== 1'b0) begin
      n_fail++;
      $display("FAIL single shift: cen=%b so=%b ready=%b set=%b, required 1 1 0 0", cen_c, so_c, rdy_c, set_c);
    end
    @(negedge clk);
    n_checks++;
    if (set_c !== 1'b1 || cen_c !== 1'b0 || so_c !== 1'b0 || bs_c !== 1'b1) begin
      n_fail++;
      $display("FAIL single set: set=%b cen=%b so=%b bits_sent=%0d, required 1 0 0 1", set_c, cen_c, so_c, bs_c);
    end
    @(negedge clk);
    n_checks++;
    if (done_c !== 1'b1 || set_c !== 1'b0 || busy_c !== 1'b0 || bs_c !== 1'b1) begin
      n_fail++;
      $display("FAIL single done: done=%b set=%b busy=%b bits_sent=%0d, required 1 0 0 1", done_c, set_c, busy_c, bs_c);
    end
  endtask

  initial begin
    rst = 1;
    @(negedge clk);
    test_reset;
    test_basic_load;
    test_valid_gap;
    test_mid_reset;
    test_start_spam;
    test_two_words;
    test_single_bit;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
